// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one input stream and NUM_OUTPUTS output streams.
// slave is the demux side, master is the producer/consumer side.
interface stream_demux_if #(
    parameter int NUM_OUTPUTS = 4,
    parameter int WIDTH_DATA  = 8
);
    localparam int WIDTH_SELECT = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    logic [WIDTH_DATA-1:0]                   in_data;
    logic [WIDTH_SELECT-1:0]                 in_sel;
    logic                                    in_last;
    logic                                    in_valid;
    logic                                    in_ready;
    logic [NUM_OUTPUTS-1:0][WIDTH_DATA-1:0]  out_data;
    logic [NUM_OUTPUTS-1:0]                  out_last;
    logic [NUM_OUTPUTS-1:0]                  out_valid;
    logic [NUM_OUTPUTS-1:0]                  out_ready;

    modport slave (
        input  in_data, in_sel, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_valid
    );

    modport master (
        output in_data, in_sel, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_valid
    );
endinterface

// File: rtl/stream_demux.sv
// Packet demultiplexer: routes one valid/ready byte stream to one of NUM_OUTPUTS registered outputs.
// Optional per-channel drained-beat counters are enabled with macro STREAM_DEMUX_COUNT_EN.
//
// state | meaning
// IDLE  | waiting for a packet start; destination comes from in_sel
// ROUTE | mid-packet; destination locked in dst_q until the beat with in_last
module stream_demux #(
    parameter int NUM_OUTPUTS = 4,
    parameter int WIDTH_DATA  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    stream_demux_if.slave               s,
    output logic                        busy,
    output logic                        err_sel,
    output logic [NUM_OUTPUTS-1:0][15:0] beat_count
);
    localparam int WIDTH_SELECT = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    typedef enum logic {IDLE, ROUTE} state_t;

    state_t                                 state_q;
    logic [WIDTH_SELECT-1:0]                dst_q;
    logic                                   err_sel_q;
    logic [WIDTH_SELECT-1:0]                dst;
    logic                                   dst_ok;
    logic                                   sel_ready;
    logic                                   accept;
    logic [NUM_OUTPUTS-1:0]                 load;
    logic [NUM_OUTPUTS-1:0][WIDTH_DATA-1:0] out_data_q;
    logic [NUM_OUTPUTS-1:0]                 out_last_q;
    logic [NUM_OUTPUTS-1:0]                 out_valid_q;

    // An unmapped destination reads as always-ready so the packet is swallowed.
    always_comb begin
        dst       = (state_q == ROUTE) ? dst_q : s.in_sel;
        dst_ok    = 1'b0;
        sel_ready = 1'b1;
        load      = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (dst == WIDTH_SELECT'(k)) begin
                dst_ok    = 1'b1;
                sel_ready = ~out_valid_q[k] | s.out_ready[k];
            end
        end
        accept = s.in_valid & sel_ready;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            load[k] = accept & (dst == WIDTH_SELECT'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dst_q     <= '0;
            err_sel_q <= 1'b0;
        end else begin
            err_sel_q <= accept & (state_q == IDLE) & ~dst_ok;
            case (state_q)
                IDLE: begin
                    if (accept && !s.in_last) begin
                        dst_q   <= s.in_sel;
                        state_q <= ROUTE;
                    end
                end
                ROUTE: begin
                    if (accept && s.in_last) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Load has priority over drain so a simultaneous load/drain keeps valid high.
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_out
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data_q[k]  <= '0;
                out_last_q[k]  <= 1'b0;
                out_valid_q[k] <= 1'b0;
            end else if (load[k]) begin
                out_data_q[k]  <= s.in_data;
                out_last_q[k]  <= s.in_last;
                out_valid_q[k] <= 1'b1;
            end else if (s.out_ready[k]) begin
                out_valid_q[k] <= 1'b0;
            end
        end
    end

`ifdef STREAM_DEMUX_COUNT_EN
    logic [NUM_OUTPUTS-1:0][15:0] count_q;

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q[k] <= '0;
            end else if (out_valid_q[k] && s.out_ready[k] && (count_q[k] != 16'hFFFF)) begin
                count_q[k] <= count_q[k] + 16'd1;
            end
        end
    end

    assign beat_count = count_q;
`else
    assign beat_count = '0;
`endif

    assign s.in_ready  = sel_ready;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;
    assign s.out_valid = out_valid_q;
    assign err_sel     = err_sel_q;
    assign busy        = (state_q == ROUTE) | (|out_valid_q);

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: a 4-channel instance with a per-channel scoreboard
// and a 3-channel instance for the unmapped-select case.
module tb_stream_demux;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

`ifdef STREAM_DEMUX_COUNT_EN
    localparam logic [15:0] EXP_CNT5 = 16'd5;
`else
    localparam logic [15:0] EXP_CNT5 = 16'd0;
`endif

    stream_demux_if #(.NUM_OUTPUTS(4), .WIDTH_DATA(8)) if4 ();
    stream_demux_if #(.NUM_OUTPUTS(3), .WIDTH_DATA(8)) if3 ();

    logic       busy4, err4, busy3, err3;
    logic [3:0][15:0] cnt4;
    logic [2:0][15:0] cnt3;

    stream_demux #(.NUM_OUTPUTS(4), .WIDTH_DATA(8)) u4 (
        .clk(clk), .rst_n(rst_n), .s(if4.slave),
        .busy(busy4), .err_sel(err4), .beat_count(cnt4)
    );

    stream_demux #(.NUM_OUTPUTS(3), .WIDTH_DATA(8)) u3 (
        .clk(clk), .rst_n(rst_n), .s(if3.slave),
        .busy(busy3), .err_sel(err3), .beat_count(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {data,last} per channel of the 4-channel instance
    logic [8:0] sb [4][$];

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (if4.out_valid[k] && if4.out_ready[k]) begin
                    vectors++;
                    if (sb[k].size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_unexpected ch%0d: got data=%h last=%b, required no beat", k,
                                 if4.out_data[k], if4.out_last[k]);
                    end else begin
                        logic [8:0] e;
                        e = sb[k].pop_front();
                        if ({if4.out_data[k], if4.out_last[k]} !== e) begin
                            miscompares++;
                            $display("FAIL sb_beat ch%0d: got data=%h last=%b, required data=%h last=%b", k,
                                     if4.out_data[k], if4.out_last[k], e[8:1], e[0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic clear_sb();
        for (int k = 0; k < 4; k++) sb[k].delete();
    endtask

    // Enter at posedge+1; returns at posedge+1 after the beat transferred, with in_valid dropped.
    task automatic send_beat(input int ch, input logic [7:0] d, input logic [1:0] sel,
                             input logic last, output int waits);
        waits = 0;
        if4.in_data  = d;
        if4.in_sel   = sel;
        if4.in_last  = last;
        if4.in_valid = 1'b1;
        @(negedge clk);
        while (!if4.in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        vectors++;
        if (!if4.in_ready) begin
            miscompares++;
            $display("FAIL send_timeout ch%0d: in_ready=%b after %0d cycles, required 1", ch, if4.in_ready, waits);
        end else begin
            sb[ch].push_back({d, last});
        end
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
    endtask

    task automatic check_sb_empty(input string tag);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (sb[k].size() != 0) begin
                miscompares++;
                $display("FAIL %s_pending ch%0d: %0d beats undelivered, required 0", tag, k, sb[k].size());
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (if4.out_valid !== 4'b0 || if3.out_valid !== 3'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b/%b, required 0000/000", if4.out_valid, if3.out_valid);
        end
        vectors++;
        if (if4.out_data !== '0 || if4.out_last !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_data: got data=%h last=%b, required 0", if4.out_data, if4.out_last);
        end
        vectors++;
        if (busy4 !== 1'b0 || err4 !== 1'b0 || busy3 !== 1'b0 || err3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy=%b%b err=%b%b, required 0", busy4, busy3, err4, err3);
        end
        vectors++;
        if (cnt4 !== '0 || cnt3 !== '0) begin
            miscompares++;
            $display("FAIL reset_count: got %h/%h, required 0", cnt4, cnt3);
        end
        vectors++;
        if (if4.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, required 1", if4.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_single();
        int w;
        if4.out_ready = 4'hF;
        send_beat(2, 8'hA5, 2'd2, 1'b1, w);
        vectors++;
        if (if4.out_valid !== 4'b0100 || if4.out_data[2] !== 8'hA5 || if4.out_last[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_route: got valid=%b data=%h last=%b, required 0100 a5 1",
                     if4.out_valid, if4.out_data[2], if4.out_last[2]);
        end
        vectors++;
        if (busy4 !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy: got %b, required 1", busy4);
        end
        // FSM stayed in IDLE: the next in_sel is honoured immediately
        send_beat(0, 8'h3C, 2'd0, 1'b1, w);
        vectors++;
        if (if4.out_valid !== 4'b0001 || if4.out_data[0] !== 8'h3C) begin
            miscompares++;
            $display("FAIL single_idle: got valid=%b data=%h, required 0001 3c", if4.out_valid, if4.out_data[0]);
        end
        idle();
        check_sb_empty("single");
    endtask

    task automatic test_packet_lock();
        int w;
        send_beat(1, 8'h11, 2'd1, 1'b0, w);
        send_beat(1, 8'h22, 2'd3, 1'b0, w);
        send_beat(1, 8'h33, 2'd3, 1'b1, w);
        vectors++;
        if (if4.out_valid !== 4'b0010 || if4.out_last[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_last: got valid=%b last=%b, required 0010 1", if4.out_valid, if4.out_last[1]);
        end
        idle();
        vectors++;
        if (busy4 !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_busy_end: got %b, required 0", busy4);
        end
        check_sb_empty("lock");
    endtask

    task automatic test_backpressure();
        int w;
        if4.out_ready = 4'b1110;
        send_beat(0, 8'h5A, 2'd0, 1'b0, w);
        if4.in_data  = 8'hC3;
        if4.in_sel   = 2'd2;
        if4.in_last  = 1'b1;
        if4.in_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (if4.in_ready !== 1'b0 || if4.out_valid[0] !== 1'b1 || if4.out_data[0] !== 8'h5A) begin
            miscompares++;
            $display("FAIL bp_stall: got in_ready=%b valid=%b data=%h, required 0 1 5a",
                     if4.in_ready, if4.out_valid[0], if4.out_data[0]);
        end
        idle();
        idle();
        @(negedge clk);
        vectors++;
        if (if4.out_valid[0] !== 1'b1 || if4.out_data[0] !== 8'h5A || if4.out_last[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold: got valid=%b data=%h last=%b, required 1 5a 0",
                     if4.out_valid[0], if4.out_data[0], if4.out_last[0]);
        end
        idle();
        if4.out_ready = 4'hF;
        @(negedge clk);
        vectors++;
        if (if4.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got in_ready=%b, required 1", if4.in_ready);
        end
        sb[0].push_back({8'hC3, 1'b1});
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        vectors++;
        if (if4.out_valid[0] !== 1'b1 || if4.out_data[0] !== 8'hC3 || if4.out_last[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_nobubble: got valid=%b data=%h last=%b, required 1 c3 1",
                     if4.out_valid[0], if4.out_data[0], if4.out_last[0]);
        end
        idle();
        // a stalled channel outside the current packet must not block others
        if4.out_ready = 4'b1110;
        send_beat(0, 8'h77, 2'd0, 1'b1, w);
        send_beat(1, 8'h88, 2'd1, 1'b1, w);
        vectors++;
        if (w !== 0 || if4.out_valid[0] !== 1'b1 || if4.out_data[0] !== 8'h77) begin
            miscompares++;
            $display("FAIL bp_isolate: got waits=%0d valid0=%b data0=%h, required 0 1 77",
                     w, if4.out_valid[0], if4.out_data[0]);
        end
        if4.out_ready = 4'hF;
        idle();
        idle();
        check_sb_empty("bp");
    endtask

    task automatic test_invalid_sel();
        if3.out_ready = 3'b111;
        if3.in_data   = 8'h99;
        if3.in_sel    = 2'd3;
        if3.in_last   = 1'b0;
        if3.in_valid  = 1'b1;
        @(negedge clk);
        vectors++;
        if (if3.in_ready !== 1'b1 || busy3 !== 1'b0 || err3 !== 1'b0) begin
            miscompares++;
            $display("FAIL inv_first: got in_ready=%b busy=%b err=%b, required 1 0 0", if3.in_ready, busy3, err3);
        end
        @(posedge clk); #1;
        vectors++;
        if (err3 !== 1'b1 || busy3 !== 1'b1 || if3.out_valid !== 3'b000) begin
            miscompares++;
            $display("FAIL inv_pulse: got err=%b busy=%b valid=%b, required 1 1 000", err3, busy3, if3.out_valid);
        end
        if3.in_data = 8'h9A;
        if3.in_sel  = 2'd0;
        if3.in_last = 1'b1;
        @(negedge clk);
        vectors++;
        if (if3.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL inv_second_ready: got %b, required 1", if3.in_ready);
        end
        @(posedge clk); #1;
        if3.in_valid = 1'b0;
        vectors++;
        if (err3 !== 1'b0 || busy3 !== 1'b0 || if3.out_valid !== 3'b000) begin
            miscompares++;
            $display("FAIL inv_end: got err=%b busy=%b valid=%b, required 0 0 000", err3, busy3, if3.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        if4.out_ready = 4'hF;
        send_beat(1, 8'h44, 2'd1, 1'b0, w);
        rst_n = 1'b0;
        #1;
        clear_sb();
        vectors++;
        if (if4.out_valid !== 4'b0000 || busy4 !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_clear: got valid=%b busy=%b, required 0000 0", if4.out_valid, busy4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        send_beat(0, 8'h66, 2'd0, 1'b1, w);
        vectors++;
        if (if4.out_valid !== 4'b0001 || if4.out_data[0] !== 8'h66 || if4.out_last[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_restart: got valid=%b data=%h, required 0001 66", if4.out_valid, if4.out_data[0]);
        end
        idle();
        check_sb_empty("rstmid");
    endtask

    task automatic test_count();
        int w;
        rst_n = 1'b0;
        clear_sb();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        if4.out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            send_beat(3, 8'hD0 + 8'(i), 2'd3, (i == 4), w);
        end
        idle();
        idle();
        vectors++;
        if (cnt4[3] !== EXP_CNT5) begin
            miscompares++;
            $display("FAIL count_ch3: got %0d, required %0d", cnt4[3], EXP_CNT5);
        end
        vectors++;
        if (cnt4[0] !== 16'd0 || cnt4[1] !== 16'd0 || cnt4[2] !== 16'd0 || cnt3 !== '0) begin
            miscompares++;
            $display("FAIL count_others: got %h/%h, required 0", cnt4[2:0], cnt3);
        end
        check_sb_empty("count");
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b1;
        if4.in_data   = '0;
        if4.in_sel    = '0;
        if4.in_last   = 1'b0;
        if4.in_valid  = 1'b0;
        if4.out_ready = 4'hF;
        if3.in_data   = '0;
        if3.in_sel    = '0;
        if3.in_last   = 1'b0;
        if3.in_valid  = 1'b0;
        if3.out_ready = 3'b111;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_packet_lock();
        test_backpressure();
        test_invalid_sel();
        test_reset_mid();
        test_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
